// File: rtl/pre_memory_stage_pkg.sv
// Shared types for the pre-memory stage: pipeline buses, op encodings,
// exception codes and the data-request FSM state.
package pre_memory_stage_pkg;

    // One-hot load op bit positions
    localparam int LD_LB  = 0;
    localparam int LD_LBU = 1;
    localparam int LD_LH  = 2;
    localparam int LD_LHU = 3;
    localparam int LD_LW  = 4;
    localparam int LD_LWL = 5;
    localparam int LD_LWR = 6;
    localparam int NUM_LD = 7;

    // One-hot store op bit positions
    localparam int ST_SB  = 0;
    localparam int ST_SH  = 1;
    localparam int ST_SW  = 2;
    localparam int ST_SWL = 3;
    localparam int ST_SWR = 4;
    localparam int NUM_ST = 5;

    typedef logic [NUM_LD-1:0] load_op_t;
    typedef logic [NUM_ST-1:0] store_op_t;

    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        ex;
        logic        bd;
        logic [4:0]  exccode;
        logic [31:0] badvaddr;
    } exception_t;

    typedef struct packed {
        logic ex;
        logic eret;
    } pipeline_flush_t;

    typedef struct packed {
        logic        valid;
        load_op_t    load_op;
        store_op_t   store_op;
        logic        op_mfc0;
        logic        op_tlb;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] rt_value;
        exception_t  exception;
    } es_to_pms_bus_t;

    typedef struct packed {
        logic        valid;
        load_op_t    load_op;
        logic        op_mfc0;
        logic        op_tlb;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] rt_value;
        exception_t  exception;
    } pms_to_ms_bus_t;

    typedef struct packed {
        logic        op_mfc0;
        logic        res_from_mem;
        logic        op_tlb;
        logic [4:0]  dest;
        logic [31:0] result;
    } pms_forward_bus_t;

    typedef enum logic [1:0] {IDLE, REQ, DONE, CANCEL} pms_state_t;

endpackage

// File: rtl/pre_memory_stage_if.sv
// Data-SRAM request channel: PMS drives the request, memory answers addr_ok.
interface pre_memory_stage_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok
    );
endinterface

// File: rtl/pre_memory_stage_mem_align.sv
// pms_mem_align: pure combinational translation of a load/store op plus
// address and rt into SRAM size, aligned address, byte strobes, lane data
// and alignment faults.
module pms_mem_align
    import pre_memory_stage_pkg::*;
(
    input  load_op_t    load_op,
    input  store_op_t   store_op,
    input  logic [31:0] addr,
    input  logic [31:0] rt,
    output logic [1:0]  size,
    output logic [31:0] req_addr,
    output logic [3:0]  strobe,
    output logic [31:0] wdata,
    output logic        adel,
    output logic        ades
);
    logic [1:0] a;
    logic       partial;
    logic [4:0] shl_amt, shr_amt;

    assign a       = addr[1:0];
    assign shl_amt = {a, 3'b000};
    assign shr_amt = {~a, 3'b000};   // 8*(3-a)

    // Unaligned-word ops always fetch the whole aligned word; lanes pick bytes.
    assign partial  = load_op[LD_LWL] | load_op[LD_LWR] | store_op[ST_SWL] | store_op[ST_SWR];
    assign req_addr = partial ? {addr[31:2], 2'b00} : addr;

    assign adel = ((load_op[LD_LH] | load_op[LD_LHU]) & a[0]) | (load_op[LD_LW] & (|a));
    assign ades = (store_op[ST_SH] & a[0]) | (store_op[ST_SW] & (|a));

    // Access size; the partial-word ops travel as full words.
    always_comb begin
        size = SIZE_WORD;
        if (load_op[LD_LB] | load_op[LD_LBU] | store_op[ST_SB])
            size = SIZE_BYTE;
        else if (load_op[LD_LH] | load_op[LD_LHU] | store_op[ST_SH])
            size = SIZE_HALF;
    end

    // Byte enables and lane-aligned store data; loads drive neither.
    always_comb begin
        strobe = 4'b0000;
        wdata  = 32'h0;
        if (store_op[ST_SB]) begin
            strobe = 4'b0001 << a;
            wdata  = {4{rt[7:0]}};
        end else if (store_op[ST_SH]) begin
            strobe = a[1] ? 4'b1100 : 4'b0011;
            wdata  = {2{rt[15:0]}};
        end else if (store_op[ST_SW]) begin
            strobe = 4'b1111;
            wdata  = rt;
        end else if (store_op[ST_SWL]) begin
            strobe = 4'b1111 >> ~a;
            wdata  = rt >> shr_amt;
        end else if (store_op[ST_SWR]) begin
            strobe = 4'b1111 << a;
            wdata  = rt << shl_amt;
        end
    end
endmodule

// File: rtl/pre_memory_stage.sv
// pre_memory_stage: execute->memory stage. Registers the EXE bus, flags
// unaligned accesses, issues and holds the data-SRAM request, and reports
// requests that were already accepted when their instruction got flushed.
module pre_memory_stage
    import pre_memory_stage_pkg::*;
#(
    parameter bit ALLOW_UNALIGNED = 1'b0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ms_allowin,
    output logic               pms_allowin,
    input  es_to_pms_bus_t     es_to_pms_bus,
    output pms_to_ms_bus_t     pms_to_ms_bus,
    output pms_forward_bus_t   pms_forward_bus,
    output logic               pms_wr_disable,
    input  logic               wr_disable,
    input  pipeline_flush_t    pipeline_flush,
    pre_memory_stage_if.master data_if,
    output logic               pms_req_cancel
);
    es_to_pms_bus_t pms_r;          // .valid is the stage valid bit
    pms_state_t     state, state_nxt;
    logic           pms_valid, flush, addr_ok;
    logic           mem_op, in_req, req, pms_ready_go;
    logic [1:0]     al_size;
    logic [31:0]    al_addr, al_wdata;
    logic [3:0]     al_strobe;
    logic           al_adel, al_ades;
    exception_t     exc;

    assign pms_valid = pms_r.valid;
    assign flush     = pipeline_flush.ex | pipeline_flush.eret;
    assign addr_ok   = data_if.data_addr_ok;

    pms_mem_align u_align (
        .load_op  (pms_r.load_op),
        .store_op (pms_r.store_op),
        .addr     (pms_r.alu_result),
        .rt       (pms_r.rt_value),
        .size     (al_size),
        .req_addr (al_addr),
        .strobe   (al_strobe),
        .wdata    (al_wdata),
        .adel     (al_adel),
        .ades     (al_ades)
    );

    // Upstream exception wins; otherwise raise AdEL/AdES keeping bd.
    always_comb begin
        exc = pms_r.exception;
        if (!pms_r.exception.ex && !ALLOW_UNALIGNED && (al_adel || al_ades)) begin
            exc.ex       = 1'b1;
            exc.exccode  = al_adel ? EXCCODE_ADEL : EXCCODE_ADES;
            exc.badvaddr = pms_r.alu_result;
        end
    end

    assign mem_op = pms_valid && ((|pms_r.load_op) || (|pms_r.store_op)) && !exc.ex && !wr_disable;
    // IDLE with a pending op already behaves as REQ so the request goes out this cycle.
    assign in_req = (state == REQ) || (state == IDLE && mem_op);

    // Stage register; flush beats latching, payload is held when only valid drops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            pms_r <= '0;
        else if (flush)
            pms_r.valid <= 1'b0;
        else if (es_to_pms_bus.valid && pms_allowin)
            pms_r <= es_to_pms_bus;
        else if (pms_ready_go && ms_allowin)
            pms_r.valid <= 1'b0;
    end

    // Request FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Request FSM next state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, REQ: begin
                if (in_req) begin
                    if (flush)        state_nxt = addr_ok ? IDLE : CANCEL;
                    else if (addr_ok) state_nxt = ms_allowin ? IDLE : DONE;
                    else              state_nxt = REQ;
                end
            end
            DONE:    if (flush || ms_allowin) state_nxt = IDLE;
            CANCEL:  if (addr_ok)             state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request FSM outputs: request strobe, stage ready, cancel pulse.
    always_comb begin
        req            = in_req || (state == CANCEL);
        pms_ready_go   = !mem_op || (in_req && addr_ok) || (state == DONE);
        pms_req_cancel = (in_req && flush && addr_ok)
                      || (state == DONE && flush)
                      || (state == CANCEL && addr_ok);
    end

    assign pms_allowin = (!pms_valid || (pms_ready_go && ms_allowin)) && (state != CANCEL);

    assign data_if.data_req   = req;
    assign data_if.data_wr    = req && (|pms_r.store_op);
    assign data_if.data_size  = req ? al_size   : 2'd0;
    assign data_if.data_addr  = req ? al_addr   : 32'h0;
    assign data_if.data_wstrb = req ? al_strobe : 4'h0;
    assign data_if.data_wdata = req ? al_wdata  : 32'h0;

    assign pms_wr_disable = pms_valid && exc.ex;

    // MEM bus and decode forwarding; forward fields vanish when the stage is empty.
    always_comb begin
        pms_to_ms_bus           = '0;
        pms_to_ms_bus.valid     = pms_valid && pms_ready_go;
        pms_to_ms_bus.load_op   = pms_r.load_op;
        pms_to_ms_bus.op_mfc0   = pms_r.op_mfc0;
        pms_to_ms_bus.op_tlb    = pms_r.op_tlb;
        pms_to_ms_bus.dest      = pms_r.dest;
        pms_to_ms_bus.result    = pms_r.alu_result;
        pms_to_ms_bus.rt_value  = pms_r.rt_value;
        pms_to_ms_bus.exception = exc;

        pms_forward_bus = '0;
        if (pms_valid) begin
            pms_forward_bus.op_mfc0      = pms_r.op_mfc0;
            pms_forward_bus.res_from_mem = |pms_r.load_op;
            pms_forward_bus.op_tlb       = pms_r.op_tlb;
            pms_forward_bus.dest         = pms_r.dest;
            pms_forward_bus.result       = pms_r.alu_result;
        end
    end
endmodule

// File: tb/tb_pre_memory_stage.sv
// Directed scenarios followed by a randomized run checked against a
// transaction-level model (expected request and handoff queues).
module tb_pre_memory_stage;
    import pre_memory_stage_pkg::*;

    localparam int K_NOP = 0, K_LB = 1, K_LBU = 2, K_LH = 3, K_LHU = 4, K_LW = 5, K_LWL = 6,
                   K_LWR = 7, K_SB = 8, K_SH = 9, K_SW = 10, K_SWL = 11, K_SWR = 12;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [4:0]  dest;
        logic        up_ex;
    } instr_t;

    logic             clk = 1'b0;
    logic             resetn;
    logic             ms_allowin, pms_allowin, pms_wr_disable, wr_disable, pms_req_cancel;
    es_to_pms_bus_t   es;
    pms_to_ms_bus_t   ms;
    pms_forward_bus_t fw;
    pipeline_flush_t  fl;

    pre_memory_stage_if dif();

    pre_memory_stage #(.ALLOW_UNALIGNED(1'b0)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ms_allowin      (ms_allowin),
        .pms_allowin     (pms_allowin),
        .es_to_pms_bus   (es),
        .pms_to_ms_bus   (ms),
        .pms_forward_bus (fw),
        .pms_wr_disable  (pms_wr_disable),
        .wr_disable      (wr_disable),
        .pipeline_flush  (fl),
        .data_if         (dif),
        .pms_req_cancel  (pms_req_cancel)
    );

    always #5 clk = ~clk;

    int     vectors = 0, miscompares = 0;
    instr_t req_q[$], ho_q[$];
    instr_t cur;
    bit     have = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(int k, logic [31:0] a, logic [31:0] rt, logic [4:0] d, logic ue);
        instr_t i;
        i.kind = k; i.addr = a; i.rt = rt; i.dest = d; i.up_ex = ue;
        return i;
    endfunction

    function automatic es_to_pms_bus_t make_es(instr_t i);
        es_to_pms_bus_t e = '0;
        e.valid = 1'b1;
        case (i.kind)
            K_LB:  e.load_op[LD_LB]   = 1'b1;
            K_LBU: e.load_op[LD_LBU]  = 1'b1;
            K_LH:  e.load_op[LD_LH]   = 1'b1;
            K_LHU: e.load_op[LD_LHU]  = 1'b1;
            K_LW:  e.load_op[LD_LW]   = 1'b1;
            K_LWL: e.load_op[LD_LWL]  = 1'b1;
            K_LWR: e.load_op[LD_LWR]  = 1'b1;
            K_SB:  e.store_op[ST_SB]  = 1'b1;
            K_SH:  e.store_op[ST_SH]  = 1'b1;
            K_SW:  e.store_op[ST_SW]  = 1'b1;
            K_SWL: e.store_op[ST_SWL] = 1'b1;
            K_SWR: e.store_op[ST_SWR] = 1'b1;
            default: ;
        endcase
        e.dest       = i.dest;
        e.alu_result = i.addr;
        e.rt_value   = i.rt;
        if (i.up_ex) begin
            e.exception.ex       = 1'b1;
            e.exception.bd       = 1'b1;
            e.exception.exccode  = 5'd10;
            e.exception.badvaddr = 32'hDEAD0000;
        end
        return e;
    endfunction

    function automatic bit is_mem(int k);
        return k >= K_LB && k <= K_SWR;
    endfunction

    // Architectural exception outcome for one instruction.
    function automatic void model_exc(instr_t i, output logic ex, output logic [4:0] code,
                                      output logic [31:0] bad);
        int  off = int'(i.addr % 4);
        bit  mis = ((i.kind == K_LH || i.kind == K_LHU || i.kind == K_SH) && (off % 2 != 0))
                || ((i.kind == K_LW || i.kind == K_SW) && off != 0);
        ex = 1'b0; code = 5'd0; bad = 32'h0;
        if (i.up_ex) begin
            ex = 1'b1; code = 5'd10; bad = 32'hDEAD0000;
        end else if (mis) begin
            ex = 1'b1; code = (i.kind >= K_SB) ? 5'd4 + 5'd1 : 5'd4; bad = i.addr;
        end
    endfunction

    // Expected SRAM request, built lane by lane from which rt byte lands where.
    function automatic void model_req(instr_t i, output logic [1:0] sz, output logic [31:0] ad,
                                      output logic [3:0] sb, output logic [31:0] wd,
                                      output logic wr);
        int a = int'(i.addr % 4);
        sz = (i.kind == K_LB || i.kind == K_LBU || i.kind == K_SB) ? 2'd0 :
             (i.kind == K_LH || i.kind == K_LHU || i.kind == K_SH) ? 2'd1 : 2'd2;
        ad = (i.kind == K_LWL || i.kind == K_LWR || i.kind == K_SWL || i.kind == K_SWR)
             ? i.addr - (i.addr % 4) : i.addr;
        wr = (i.kind >= K_SB);
        sb = 4'h0; wd = 32'h0;
        for (int l = 0; l < 4; l++) begin
            int src = -1;
            bit on  = 1'b0;
            case (i.kind)
                K_SB:  begin src = 0;     on = (l == a);         end
                K_SH:  begin src = l % 2; on = (l / 2 == a / 2); end
                K_SW:  begin src = l;     on = 1'b1;             end
                K_SWL: begin on = (l <= a); if (on) src = l + 3 - a; end
                K_SWR: begin on = (l >= a); if (on) src = l - a;     end
                default: ;
            endcase
            sb[l] = on;
            if (src >= 0) wd[8*l +: 8] = i.rt[8*src +: 8];
        end
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.kind  = int'($urandom_range(0, 12));
        i.addr  = $urandom;
        i.rt    = $urandom;
        i.dest  = 5'($urandom_range(1, 31));
        i.up_ex = ($urandom_range(0, 9) == 0);
        return i;
    endfunction

    // Score one low-phase sample: accepted requests, MEM handoffs, new latches.
    task automatic monitor_step();
        instr_t r;
        logic [1:0] esz; logic [31:0] ead, ewd, ebad; logic [3:0] esb; logic ewr, eex;
        logic [4:0] ecode;
        if (dif.data_req && dif.data_addr_ok) begin
            check("rnd_req_expected", req_q.size() > 0, 1);
            if (req_q.size() > 0) begin
                r = req_q.pop_front();
                model_req(r, esz, ead, esb, ewd, ewr);
                check("rnd_req_addr", dif.data_addr, ead);
                check("rnd_req_size", dif.data_size, esz);
                check("rnd_req_wstrb", dif.data_wstrb, esb);
                check("rnd_req_wdata", dif.data_wdata, ewd);
                check("rnd_req_wr", dif.data_wr, ewr);
            end
        end
        if (ms.valid && ms_allowin) begin
            check("rnd_handoff_expected", ho_q.size() > 0, 1);
            if (ho_q.size() > 0) begin
                r = ho_q.pop_front();
                model_exc(r, eex, ecode, ebad);
                check("rnd_ho_dest", ms.dest, r.dest);
                check("rnd_ho_result", ms.result, r.addr);
                check("rnd_ho_ex", ms.exception.ex, eex);
                if (eex) begin
                    check("rnd_ho_exccode", ms.exception.exccode, ecode);
                    check("rnd_ho_badvaddr", ms.exception.badvaddr, ebad);
                end
            end
        end
        if (es.valid && pms_allowin) begin
            model_exc(cur, eex, ecode, ebad);
            ho_q.push_back(cur);
            if (is_mem(cur.kind) && !eex) req_q.push_back(cur);
            have = 0;
        end
    endtask

    task automatic send(instr_t i);
        es = make_es(i);
        @(negedge clk);
        es = '0;
    endtask

    initial begin
        int req_cycles, handoffs;
        ms_allowin = 1'b1; wr_disable = 1'b0; fl = '0; es = '0;
        dif.data_addr_ok = 1'b0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check("rst_allowin", pms_allowin, 1);
        check("rst_req", dif.data_req, 0);
        check("rst_ms_valid", ms.valid, 0);
        check("rst_fwd", fw, 0);
        check("rst_wr_disable", pms_wr_disable, 0);
        check("rst_cancel", pms_req_cancel, 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // sw, addr_ok on the third request cycle
        send(mk(K_SW, 32'h1000, 32'hAABBCCDD, 5'd3, 1'b0));
        req_cycles = 0; handoffs = 0;
        for (int c = 0; c < 8; c++) begin
            dif.data_addr_ok = (c == 2);
            #1;
            if (dif.data_req) req_cycles++;
            if (c == 2) begin
                check("sw_wstrb", dif.data_wstrb, 4'hF);
                check("sw_wdata", dif.data_wdata, 32'hAABBCCDD);
                check("sw_addr", dif.data_addr, 32'h1000);
                check("sw_size", dif.data_size, 2);
                check("sw_wr", dif.data_wr, 1);
            end
            if (ms.valid && ms_allowin) handoffs++;
            @(negedge clk);
        end
        dif.data_addr_ok = 1'b0;
        check("sw_req_cycles", req_cycles, 3);
        check("sw_handoffs", handoffs, 1);

        // sb to the top byte lane
        send(mk(K_SB, 32'h1003, 32'h00000011, 5'd4, 1'b0));
        dif.data_addr_ok = 1'b1;
        #1;
        check("sb_req", dif.data_req, 1);
        check("sb_wstrb", dif.data_wstrb, 4'b1000);
        check("sb_wdata", dif.data_wdata, 32'h11111111);
        check("sb_size", dif.data_size, 0);
        @(negedge clk);
        dif.data_addr_ok = 1'b0;

        // swl with a=1
        send(mk(K_SWL, 32'h1001, 32'hAABBCCDD, 5'd5, 1'b0));
        dif.data_addr_ok = 1'b1;
        #1;
        check("swl_wstrb", dif.data_wstrb, 4'b0011);
        check("swl_wdata", dif.data_wdata, 32'h0000AABB);
        check("swl_addr", dif.data_addr, 32'h1000);
        check("swl_size", dif.data_size, 2);
        @(negedge clk);
        dif.data_addr_ok = 1'b0;

        // misaligned lw raises AdEL and never requests
        send(mk(K_LW, 32'h1002, 32'h0, 5'd6, 1'b0));
        #1;
        check("adel_req", dif.data_req, 0);
        check("adel_ms_valid", ms.valid, 1);
        check("adel_ex", ms.exception.ex, 1);
        check("adel_code", ms.exception.exccode, 4);
        check("adel_badvaddr", ms.exception.badvaddr, 32'h1002);
        check("adel_wr_disable", pms_wr_disable, 1);
        check("adel_fwd_dest", fw.dest, 6);
        check("adel_fwd_mem", fw.res_from_mem, 1);
        @(negedge clk);
        #1;
        check("adel_wr_disable_clr", pms_wr_disable, 0);
        check("empty_fwd", fw, 0);

        // wr_disable suppresses the request, instr still passes on
        wr_disable = 1'b1;
        send(mk(K_LW, 32'h1004, 32'h0, 5'd7, 1'b0));
        #1;
        check("wrdis_req", dif.data_req, 0);
        check("wrdis_ms_valid", ms.valid, 1);
        @(negedge clk);
        wr_disable = 1'b0;

        // flush in REQ before addr_ok: request held, then cancelled
        send(mk(K_LW, 32'h2000, 32'h0, 5'd8, 1'b0));
        @(negedge clk);
        fl.ex = 1'b1;
        #1;
        check("fl_req_in_req", dif.data_req, 1);
        check("fl_no_cancel_yet", pms_req_cancel, 0);
        @(negedge clk);
        fl = '0;
        #1;
        check("cxl_req_held", dif.data_req, 1);
        check("cxl_addr_held", dif.data_addr, 32'h2000);
        check("cxl_allowin", pms_allowin, 0);
        @(negedge clk);
        dif.data_addr_ok = 1'b1;
        #1;
        check("cxl_pulse", pms_req_cancel, 1);
        check("cxl_no_handoff", ms.valid, 0);
        @(negedge clk);
        dif.data_addr_ok = 1'b0;
        #1;
        check("cxl_pulse_end", pms_req_cancel, 0);
        check("cxl_req_end", dif.data_req, 0);
        check("cxl_allowin_back", pms_allowin, 1);

        // addr_ok while MEM is stalled: DONE, handoff when MEM frees up
        send(mk(K_LW, 32'h3000, 32'h0, 5'd9, 1'b0));
        ms_allowin = 1'b0;
        dif.data_addr_ok = 1'b1;
        #1;
        check("done_entry_req", dif.data_req, 1);
        check("done_entry_allowin", pms_allowin, 0);
        @(negedge clk);
        dif.data_addr_ok = 1'b0;
        #1;
        check("done_req_low", dif.data_req, 0);
        check("done_ms_valid", ms.valid, 1);
        @(negedge clk);
        ms_allowin = 1'b1;
        #1;
        check("done_allowin", pms_allowin, 1);
        check("done_handoff_dest", ms.dest, 9);
        @(negedge clk);
        #1;
        check("done_drained", ms.valid, 0);

        // flush while in DONE
        send(mk(K_SW, 32'h3004, 32'h12345678, 5'd10, 1'b0));
        ms_allowin = 1'b0;
        dif.data_addr_ok = 1'b1;
        @(negedge clk);
        dif.data_addr_ok = 1'b0;
        fl.eret = 1'b1;
        #1;
        check("done_fl_pulse", pms_req_cancel, 1);
        @(negedge clk);
        fl = '0;
        ms_allowin = 1'b1;
        #1;
        check("done_fl_pulse_end", pms_req_cancel, 0);
        check("done_fl_empty", ms.valid, 0);

        // async reset in the middle of a request
        send(mk(K_LW, 32'h4000, 32'h0, 5'd11, 1'b0));
        @(negedge clk);
        #1;
        check("arst_pre_req", dif.data_req, 1);
        #1 resetn = 1'b0;
        #1;
        check("arst_req", dif.data_req, 0);
        check("arst_ms_valid", ms.valid, 0);
        check("arst_allowin", pms_allowin, 1);
        @(negedge clk);
        resetn = 1'b1;

        // randomized traffic against the transaction model
        for (int c = 0; c < 1500; c++) begin
            if (!have && $urandom_range(0, 9) < 7) begin
                cur  = rand_instr();
                have = 1;
            end
            ms_allowin       = ($urandom_range(0, 3) != 0);
            dif.data_addr_ok = ($urandom_range(0, 2) == 0);
            es               = have ? make_es(cur) : '0;
            #1;
            monitor_step();
            @(negedge clk);
        end
        for (int c = 0; c < 200; c++) begin
            if (!have && req_q.size() == 0 && ho_q.size() == 0) break;
            ms_allowin       = 1'b1;
            dif.data_addr_ok = 1'b1;
            es               = have ? make_es(cur) : '0;
            #1;
            monitor_step();
            @(negedge clk);
        end
        es = '0;
        dif.data_addr_ok = 1'b0;
        check("drain_pending", have, 0);
        check("drain_req_q", req_q.size(), 0);
        check("drain_ho_q", ho_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
